rv_fifo_buffer: RTL and testbench



---
 rtl/rv_fifo_buffer.sv | 102 ++++++++++
 tb/tb_rv_fifo_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rv_fifo_buffer.sv
// DEPTH-entry circular ready/valid FIFO: one transfer per cycle, occupancy count, synchronous flush.
// Define RV_FIFO_BUFFER_BYPASS_EN to let an empty buffer forward data_in straight to data_out.
module rv_fifo_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush,
  input  logic                                valid_in,
  input  logic [DATA_WIDTH-1:0]               data_in,
  output logic                                ready_in,
  output logic                                valid_out,
  output logic [DATA_WIDTH-1:0]               data_out,
  input  logic                                ready_out,
  output logic [$clog2(DEPTH+1)-1:0]          count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  empty, push, pop, bypass_xfer;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    // Explicit wrap so non-power-of-two depths work.
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (cnt_q == '0);
  assign ready_in = (cnt_q != CNT_W'(DEPTH));
  assign count    = cnt_q;

`ifdef RV_FIFO_BUFFER_BYPASS_EN
  assign bypass_xfer = empty & valid_in & ready_out;
  always_comb begin
    valid_out = 1'b0;
    data_out  = '0;
    if (!empty) begin
      valid_out = 1'b1;
      data_out  = mem_q[rd_ptr_q];
    end else if (valid_in) begin
      valid_out = 1'b1;
      data_out  = data_in;
    end
  end
`else
  assign bypass_xfer = 1'b0;
  always_comb begin
    valid_out = !empty;
    data_out  = '0;
    if (!empty) data_out = mem_q[rd_ptr_q];
  end
`endif

  // A bypassed item never touches storage.
  assign push = valid_in & ready_in & ~bypass_xfer;
  assign pop  = ~empty & ready_out;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = ptr_next(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_next(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_rv_fifo_buffer.sv
// Scoreboard bench for rv_fifo_buffer: a DEPTH=4 and a DEPTH=3 instance driven by directed vectors.
module tb_rv_fifo_buffer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DEPTH=4 instance
  logic       a_flush = 0, a_valid_in = 0, a_ready_out = 0;
  logic [7:0] a_data_in = '0;
  logic       a_ready_in, a_valid_out;
  logic [7:0] a_data_out;
  logic [2:0] a_count;

  // DEPTH=3 instance
  logic       b_flush = 0, b_valid_in = 0, b_ready_out = 0;
  logic [7:0] b_data_in = '0;
  logic       b_ready_in, b_valid_out;
  logic [7:0] b_data_out;
  logic [1:0] b_count;

  rv_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(4)) u_d4 (
    .clk(clk), .reset(reset), .flush(a_flush), .valid_in(a_valid_in), .data_in(a_data_in),
    .ready_in(a_ready_in), .valid_out(a_valid_out), .data_out(a_data_out),
    .ready_out(a_ready_out), .count(a_count));

  rv_fifo_buffer #(.DATA_WIDTH(8), .DEPTH(3)) u_d3 (
    .clk(clk), .reset(reset), .flush(b_flush), .valid_in(b_valid_in), .data_in(b_data_in),
    .ready_in(b_ready_in), .valid_out(b_valid_out), .data_out(b_data_out),
    .ready_out(b_ready_out), .count(b_count));

  logic [7:0] exp4[$];
  logic [7:0] exp3[$];
  logic [7:0] e4, e3;
  int         b_rx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitors: a transfer is committed at the next rising edge when valid_out & ready_out.
  always @(negedge clk) begin
    if (!reset && a_valid_out && a_ready_out) begin
      checks++;
      if (exp4.size() == 0) begin
        errors++;
        $display("FAIL d4_unexpected_item: got %0h expected none", a_data_out);
      end else begin
        e4 = exp4.pop_front();
        if (a_data_out !== e4) begin
          errors++;
          $display("FAIL d4_data_order: got %0h expected %0h", a_data_out, e4);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && b_valid_out && b_ready_out) begin
      checks++;
      b_rx++;
      if (exp3.size() == 0) begin
        errors++;
        $display("FAIL d3_unexpected_item: got %0h expected none", b_data_out);
      end else begin
        e3 = exp3.pop_front();
        if (b_data_out !== e3) begin
          errors++;
          $display("FAIL d3_data_order: got %0h expected %0h", b_data_out, e3);
        end
      end
    end
  end

  initial begin
    logic [7:0] fill_v [4];
    fill_v[0] = 8'h11; fill_v[1] = 8'h22; fill_v[2] = 8'h33; fill_v[3] = 8'h44;

    #12 reset = 1'b0;
    cyc();
    check("reset_count", a_count, 0);
    check("reset_ready_in", a_ready_in, 1);
    check("reset_valid_out", a_valid_out, 0);
    check("reset_data_out", a_data_out, 0);

    // Mid-cycle reset discards a stored item at once.
    a_valid_in = 1; a_data_in = 8'h77;
    cyc();
    a_valid_in = 0;
    check("pre_reset_count", a_count, 1);
    #3 reset = 1'b1;
    #1;
    check("midrst_valid_out", a_valid_out, 0);
    check("midrst_ready_in", a_ready_in, 1);
    check("midrst_count", a_count, 0);
    check("midrst_data_out", a_data_out, 0);
    #1 reset = 1'b0;
    cyc();

`ifndef RV_FIFO_BUFFER_BYPASS_EN
    a_valid_in = 1; a_data_in = 8'h99;
    #1;
    check("no_bypass_valid_out", a_valid_out, 0);
    a_valid_in = 0;
    #1;
`endif

    // Fill with downstream stalled, then drain.
    for (int i = 0; i < 4; i++) begin
      a_valid_in = 1; a_data_in = fill_v[i];
      exp4.push_back(fill_v[i]);
      cyc();
    end
    check("full_count", a_count, 4);
    check("full_ready_in", a_ready_in, 0);
    a_data_in = 8'h55;
    cyc();
    a_valid_in = 0;
    check("full_reject_count", a_count, 4);
    a_ready_out = 1;
    for (int i = 3; i >= 0; i--) begin
      cyc();
      check("drain_count", a_count, i);
    end
    check("drain_valid_out", a_valid_out, 0);
    a_ready_out = 0;

    // Simultaneous push and pop at count 2.
    a_valid_in = 1; a_data_in = 8'h01; exp4.push_back(8'h01); cyc();
    a_data_in = 8'h02; exp4.push_back(8'h02); cyc();
    check("pp_pre_count", a_count, 2);
    a_data_in = 8'h03; exp4.push_back(8'h03); a_ready_out = 1;
    cyc();
    a_valid_in = 0;
    check("pp_count", a_count, 2);
    check("pp_head", a_data_out, 8'h02);
    cyc(); cyc();
    check("pp_drain_count", a_count, 0);
    a_ready_out = 0;

    // Flush at count 3 drops the concurrent push of 0xAA.
    a_valid_in = 1;
    a_data_in = 8'h0A; cyc();
    a_data_in = 8'h0B; cyc();
    a_data_in = 8'h0C; cyc();
    check("flush_pre_count", a_count, 3);
    a_flush = 1; a_data_in = 8'hAA;
    cyc();
    a_flush = 0; a_valid_in = 0;
    check("flush_count", a_count, 0);
    check("flush_valid_out", a_valid_out, 0);
    check("flush_ready_in", a_ready_in, 1);
    a_ready_out = 1;
    cyc(); cyc();
    check("post_flush_count", a_count, 0);
    a_ready_out = 0;

`ifdef RV_FIFO_BUFFER_BYPASS_EN
    a_ready_out = 1; a_valid_in = 1; a_data_in = 8'h5C;
    exp4.push_back(8'h5C);
    #1;
    check("bypass_valid_out", a_valid_out, 1);
    check("bypass_data_out", a_data_out, 8'h5C);
    cyc();
    check("bypass_count", a_count, 0);
    a_ready_out = 0;
    #1;
    check("bypass_stall_valid_out", a_valid_out, 1);
    cyc();
    a_valid_in = 0;
    check("bypass_stall_count", a_count, 1);
    exp4.push_back(8'h5C);
    a_ready_out = 1;
    cyc();
    check("bypass_drain_count", a_count, 0);
    a_ready_out = 0;
`endif

    // Streaming 20 items through DEPTH=3 with both sides always ready.
    b_ready_out = 1;
    for (int i = 0; i < 20; i++) begin
      b_valid_in = 1; b_data_in = 8'(i);
      exp3.push_back(8'(i));
      cyc();
    end
`ifdef RV_FIFO_BUFFER_BYPASS_EN
    check("stream_rx_mid", b_rx, 20);
    check("stream_count_mid", b_count, 0);
`else
    check("stream_rx_mid", b_rx, 19);
    check("stream_count_mid", b_count, 1);
`endif
    b_valid_in = 0;
    cyc();
    check("stream_rx_end", b_rx, 20);
    check("stream_count_end", b_count, 0);
    b_ready_out = 0;

    cyc();
    check("d4_scoreboard_empty", exp4.size(), 0);
    check("d3_scoreboard_empty", exp3.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
